// File: rtl/truth_table_sweeper.sv
// Exhaustive sweep controller for a 4-in/3-out combinational block.
// It drives codes 0..15, samples c/d/e after SETTLE cycles and checks the truth tables.

module truth_table_lane (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        smp,
  input  logic [3:0]  idx,
  input  logic        val,
  input  logic [15:0] mask,
  output logic [15:0] tab,
  output logic        miss
);
  assign miss = val ^ mask[idx];

  always_ff @(posedge clk) begin
    if (reset)    tab      <= '0;
    else if (clr) tab      <= '0;
    else if (smp) tab[idx] <= val;
  end
endmodule

module truth_table_sweeper #(
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] exp_c,
  input  logic [15:0] exp_d,
  input  logic [15:0] exp_e,
  input  logic        c,
  input  logic        d,
  input  logic        e,
  output logic        x,
  output logic        y,
  output logic        w,
  output logic        z,
  output logic        busy,
  output logic        done,
  output logic [15:0] tab_c,
  output logic [15:0] tab_d,
  output logic [15:0] tab_e,
  output logic        pass,
  output logic [4:0]  err_count,
  output logic [3:0]  first_fail
);
  localparam int NUM_LANES = 3;
  // A zero settle time is meaningless; run it as a single-cycle hold.
  localparam int          SET_EFF  = (SETTLE < 1) ? 1 : SETTLE;
  localparam logic [3:0]  SET_LAST = 4'(SET_EFF - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  logic [1:0] state;
  logic [3:0] idx;
  logic [3:0] cnt;

  logic [NUM_LANES-1:0]         vals;
  logic [NUM_LANES-1:0]         miss;
  logic [NUM_LANES-1:0][15:0]   masks;
  logic [NUM_LANES-1:0][15:0]   tabs;

  logic       smp;
  logic       clr;
  logic       any_miss;
  logic [4:0] err_next;

  assign vals  = {e, d, c};
  assign masks = {exp_e, exp_d, exp_c};

  assign smp      = (state == RUN) && !abort && (cnt == SET_LAST);
  assign clr      = (state == IDLE) && start;
  assign any_miss = |miss;
  assign err_next = err_count + {4'b0, any_miss};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    truth_table_lane u_lane (
      .clk   (clk),
      .reset (reset),
      .clr   (clr),
      .smp   (smp),
      .idx   (idx),
      .val   (vals[i]),
      .mask  (masks[i]),
      .tab   (tabs[i]),
      .miss  (miss[i])
    );
  end

  assign tab_c = tabs[0];
  assign tab_d = tabs[1];
  assign tab_e = tabs[2];

  assign {x, y, w, z} = idx;
  assign busy = (state == RUN);
  assign done = (state == FINISH);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      pass       <= 1'b0;
      err_count  <= '0;
      first_fail <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= RUN;
            idx        <= '0;
            cnt        <= '0;
            pass       <= 1'b0;
            err_count  <= '0;
            first_fail <= '0;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            idx   <= '0;
            cnt   <= '0;
            pass  <= 1'b0;
          end else if (cnt == SET_LAST) begin
            cnt       <= '0;
            err_count <= err_next;
            // err_count still zero means this is the sweep's first mismatch.
            if (any_miss && (err_count == 5'd0)) first_fail <= idx;
            if (idx == 4'd15) begin
              state <= FINISH;
              idx   <= '0;
              pass  <= (err_next == 5'd0);
            end else begin
              idx <= idx + 4'd1;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (SETTLE=1 and SETTLE=3) driving a modelled
// function block; table-driven sweeps with a result scoreboard plus abort/reset sequences.

module tb_truth_table_sweeper;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       reset, start, abort, c_s, d_s, e_s, busy_s, done_s, pass_s;
  logic [1:0][15:0] ec_s, ed_s, ee_s, tc_s, td_s, te_s;
  logic [1:0][3:0]  code_s, ff_s;
  logic [1:0][4:0]  err_s;

  // Attached function block: minterm masks of c, d, e.
  logic [15:0] fc = 16'h0EC6;
  logic [15:0] fd = 16'h24E5;
  logic [15:0] fe = 16'h414E;

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      c_s[k] = fc[code_s[k]];
      d_s[k] = fd[code_s[k]];
      e_s[k] = fe[code_s[k]];
    end
  end

  truth_table_sweeper #(.SETTLE(1)) u_dut1 (
    .clk(clk), .reset(reset[0]), .start(start[0]), .abort(abort[0]),
    .exp_c(ec_s[0]), .exp_d(ed_s[0]), .exp_e(ee_s[0]),
    .c(c_s[0]), .d(d_s[0]), .e(e_s[0]),
    .x(code_s[0][3]), .y(code_s[0][2]), .w(code_s[0][1]), .z(code_s[0][0]),
    .busy(busy_s[0]), .done(done_s[0]),
    .tab_c(tc_s[0]), .tab_d(td_s[0]), .tab_e(te_s[0]),
    .pass(pass_s[0]), .err_count(err_s[0]), .first_fail(ff_s[0])
  );

  truth_table_sweeper #(.SETTLE(3)) u_dut3 (
    .clk(clk), .reset(reset[1]), .start(start[1]), .abort(abort[1]),
    .exp_c(ec_s[1]), .exp_d(ed_s[1]), .exp_e(ee_s[1]),
    .c(c_s[1]), .d(d_s[1]), .e(e_s[1]),
    .x(code_s[1][3]), .y(code_s[1][2]), .w(code_s[1][1]), .z(code_s[1][0]),
    .busy(busy_s[1]), .done(done_s[1]),
    .tab_c(tc_s[1]), .tab_d(td_s[1]), .tab_e(te_s[1]),
    .pass(pass_s[1]), .err_count(err_s[1]), .first_fail(ff_s[1])
  );

  typedef struct {
    int          k;
    int          st;
    logic [15:0] ec, ed, ee;
    logic [15:0] tc, td, te;
    logic        pass;
    logic [4:0]  err;
    logic [3:0]  ff;
    int          poke;
    logic        both;
  } vec_t;

  typedef struct {
    logic [15:0] tc, td, te;
    logic        pass;
    logic [4:0]  err;
    logic [3:0]  ff;
  } res_t;

  res_t sb[$];
  vec_t vecs[7];
  int   checks = 0;
  int   passed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h want %0h", nm, act, req);
  endtask

  task automatic check_zero(input int k, input string tag);
    chk({tag, "_busy"}, busy_s[k], 0);
    chk({tag, "_done"}, done_s[k], 0);
    chk({tag, "_code"}, code_s[k], 0);
    chk({tag, "_tab_c"}, tc_s[k], 0);
    chk({tag, "_tab_d"}, td_s[k], 0);
    chk({tag, "_tab_e"}, te_s[k], 0);
    chk({tag, "_pass"}, pass_s[k], 0);
    chk({tag, "_err"}, err_s[k], 0);
    chk({tag, "_ff"}, ff_s[k], 0);
  endtask

  task automatic sweep(input vec_t v);
    int   k     = v.k;
    int   last  = 16 * v.st + 1;
    int   ndone = 0;
    bit   step_ok = 1'b1;
    res_t r;
    sb.push_back('{v.tc, v.td, v.te, v.pass, v.err, v.ff});
    ec_s[k] = v.ec; ed_s[k] = v.ed; ee_s[k] = v.ee;
    start[k] = 1'b1;
    abort[k] = v.both;
    @(negedge clk);
    start[k] = 1'b0;
    abort[k] = 1'b0;
    for (int n = 1; n <= last + 3; n++) begin
      if (n < last) begin
        if (!busy_s[k] || done_s[k] || code_s[k] != 4'((n - 1) / v.st)) step_ok = 1'b0;
      end
      if (done_s[k]) begin
        ndone++;
        if (ndone == 1) begin
          chk("done_latency", n, last);
          chk("busy_at_done", busy_s[k], 0);
          if (sb.size() > 0) begin
            r = sb.pop_front();
            chk("tab_c", tc_s[k], r.tc);
            chk("tab_d", td_s[k], r.td);
            chk("tab_e", te_s[k], r.te);
            chk("pass", pass_s[k], r.pass);
            chk("err_count", err_s[k], r.err);
            chk("first_fail", ff_s[k], r.ff);
          end
        end
      end
      start[k] = (n == v.poke);
      @(negedge clk);
    end
    start[k] = 1'b0;
    chk("code_stepping", step_ok, 1);
    chk("done_once", ndone, 1);
    sb.delete();
  endtask

  initial begin
    vecs[0] = '{0, 1, 16'h0EC6, 16'h24E5, 16'h414E, 16'h0EC6, 16'h24E5, 16'h414E, 1'b1, 5'd0, 4'd0, -1, 1'b0};
    vecs[1] = '{0, 1, 16'h0EC7, 16'h24E5, 16'h414F, 16'h0EC6, 16'h24E5, 16'h414E, 1'b0, 5'd1, 4'd0, -1, 1'b0};
    vecs[2] = '{0, 1, 16'h0EC6, 16'h27E5, 16'h414E, 16'h0EC6, 16'h24E5, 16'h414E, 1'b0, 5'd2, 4'd8, -1, 1'b0};
    vecs[3] = '{0, 1, 16'h0EC6, 16'h24E5, 16'h414E, 16'h0EC6, 16'h24E5, 16'h414E, 1'b1, 5'd0, 4'd0,  6, 1'b0};
    vecs[4] = '{0, 1, 16'h0EC6, 16'h24E5, 16'h414E, 16'h0EC6, 16'h24E5, 16'h414E, 1'b1, 5'd0, 4'd0, -1, 1'b1};
    vecs[5] = '{1, 3, 16'h0EC6, 16'h24E5, 16'h414E, 16'h0EC6, 16'h24E5, 16'h414E, 1'b1, 5'd0, 4'd0, -1, 1'b0};
    vecs[6] = '{1, 3, 16'h0EC6, 16'h27E5, 16'h414E, 16'h0EC6, 16'h24E5, 16'h414E, 1'b0, 5'd2, 4'd8, -1, 1'b0};

    reset = 2'b11; start = '0; abort = '0;
    ec_s = '0; ed_s = '0; ee_s = '0;
    repeat (3) @(negedge clk);
    check_zero(0, "reset1");
    check_zero(1, "reset3");
    reset = 2'b00;
    @(negedge clk);

    for (int i = 0; i < 7; i++) sweep(vecs[i]);

    // Abort at idx 7: partial tables survive, pass cleared, no done.
    ec_s[0] = 16'h0EC6; ed_s[0] = 16'h24E5; ee_s[0] = 16'h414E;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (7) @(negedge clk);
    chk("abort_at_idx7", code_s[0], 7);
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    chk("abort_busy", busy_s[0], 0);
    chk("abort_code", code_s[0], 0);
    chk("abort_done", done_s[0], 0);
    chk("abort_pass", pass_s[0], 0);
    chk("abort_tab_c", tc_s[0], 16'h0046);
    chk("abort_tab_d", td_s[0], 16'h0065);
    chk("abort_err", err_s[0], 0);
    begin
      int nd = 0;
      for (int n = 0; n < 20; n++) begin
        if (done_s[0] || busy_s[0]) nd++;
        @(negedge clk);
      end
      chk("abort_stays_idle", nd, 0);
    end

    // Reset at idx 10, then a clean sweep.
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (10) @(negedge clk);
    chk("reset_at_idx10", code_s[0], 10);
    reset[0] = 1'b1;
    @(negedge clk);
    check_zero(0, "midreset");
    reset[0] = 1'b0;
    @(negedge clk);
    sweep(vecs[0]);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
